alu_cmd_responder: RTL and testbench

//  Sequential command-side responder for the team's ALU opcode set: accepts (A, B, Sel) commands on a

---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_rsp_fifo.sv | 74 +++++++
 rtl/alu_cmd_responder.sv | 180 ++++++++++++++++++
 tb/tb_alu_cmd_responder.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode, state and width definitions for the ALU command responder
// Contents:
//   OP_ADD..OP_MUL  4-bit opcode encodings
//   state_t         responder FSM states (ST_IDLE, ST_EXEC)
//   res_width()     result width for a given operand width
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b1111;
  localparam logic [3:0] OP_AND = 4'b0001;
  localparam logic [3:0] OP_OR  = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_EQ  = 4'b1000;
  localparam logic [3:0] OP_GT  = 4'b0011;
  localparam logic [3:0] OP_SHL = 4'b0110;
  localparam logic [3:0] OP_SHR = 4'b1100;
  localparam logic [3:0] OP_MUL = 4'b0101;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_t;

  localparam int RES_MULT = 2;

  function automatic int res_width(input int data_w);
    return RES_MULT * data_w;
  endfunction

endpackage

// File: rtl/alu_rsp_fifo.sv
// rtl/alu_rsp_fifo.sv - synchronous response FIFO with push/pop/count
// Ports:
//   clk, rst          clock, synchronous active-high reset (empties the FIFO)
//   push, push_data   write one entry (caller guarantees a free slot)
//   pop               remove head; ignored while empty
//   head_valid        FIFO not empty
//   head_data         entry at head, forced to 0 while empty
//   count             current number of entries (0..DEPTH)
module alu_rsp_fifo #(
  parameter int W     = 9,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic                     head_valid,
  output logic [W-1:0]             head_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic          do_pop;

  assign do_pop = pop && (cnt_q != '0);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;  // power-of-2 depth: natural wrap
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push && !do_pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!push && do_pop) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: stale entries are unreachable once count is cleared.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head_valid = (cnt_q != '0);
  assign head_data  = head_valid ? mem_q[rd_ptr_q] : '0;
  assign count      = cnt_q;

endmodule

// File: rtl/alu_cmd_responder.sv
// rtl/alu_cmd_responder.sv - command-side ALU responder with response FIFO
// Accepts (a, b, sel) commands, executes one at a time (MUL iterative shift-add over
// DATA_W cycles, other ops one cycle) and queues 2*DATA_W-bit results in order.
// Optional macro ALU_CMD_STATS_EN adds stat_ops/stat_err saturating counters.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   cmd_valid/cmd_ready         command handshake; cmd_a, cmd_b operands, cmd_sel opcode
//   rsp_valid/rsp_ready         response handshake; rsp_c result, rsp_err illegal opcode
//   stat_ops, stat_err          (ALU_CMD_STATS_EN only) completed / illegal command counts
module alu_cmd_responder
  import alu_pkg::*;
#(
  parameter int DATA_W     = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [DATA_W-1:0]      cmd_a,
  input  logic [DATA_W-1:0]      cmd_b,
  input  logic [3:0]             cmd_sel,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [2*DATA_W-1:0]    rsp_c,
`ifdef ALU_CMD_STATS_EN
  output logic [15:0]            stat_ops,
  output logic [15:0]            stat_err,
`endif
  output logic                   rsp_err
);

  localparam int RES_W = res_width(DATA_W);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int IT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IT_W-1:0] IT_LAST = IT_W'(DATA_W - 1);

  state_t            state_q, state_d;
  logic [RES_W-1:0]  a_q, a_d;      // multiplicand, shifted left during MUL
  logic [DATA_W-1:0] b_q, b_d;      // multiplier, shifted right during MUL
  logic [3:0]        sel_q, sel_d;
  logic [RES_W-1:0]  acc_q, acc_d;
  logic [IT_W-1:0]   it_q, it_d;

  logic [RES_W-1:0]  b_ext, alu_c, acc_sum, push_c;
  logic              alu_err, push, push_err, pop;
  logic [CNT_W-1:0]  fifo_count;
  logic [RES_W:0]    head_data;

  assign b_ext     = {{DATA_W{1'b0}}, b_q};
  assign acc_sum   = acc_q + (b_q[0] ? a_q : '0);
  assign cmd_ready = !rst && (state_q == ST_IDLE) && (fifo_count < CNT_W'(FIFO_DEPTH));
  assign pop       = rsp_valid && rsp_ready;

  // Single-cycle ops, evaluated from the latched operands while in EXEC.
  always_comb begin
    alu_c   = '0;
    alu_err = 1'b0;
    case (sel_q)
      OP_ADD:  alu_c = a_q + b_ext;
      OP_SUB:  alu_c = a_q - b_ext;
      OP_AND:  alu_c = a_q & b_ext;
      OP_OR:   alu_c = a_q | b_ext;
      OP_XOR:  alu_c = a_q ^ b_ext;
      OP_EQ:   alu_c = {{(RES_W-1){1'b0}}, (a_q == b_ext)};
      OP_GT:   alu_c = {{(RES_W-1){1'b0}}, (a_q > b_ext)};
      OP_SHL:  alu_c = a_q << b_q;
      OP_SHR:  alu_c = a_q >> b_q;
      OP_MUL:  alu_c = '0;
      default: alu_err = 1'b1;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sel_d    = sel_q;
    acc_d    = acc_q;
    it_d     = it_q;
    push     = 1'b0;
    push_c   = '0;
    push_err = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          a_d     = {{DATA_W{1'b0}}, cmd_a};
          b_d     = cmd_b;
          sel_d   = cmd_sel;
          acc_d   = '0;
          it_d    = '0;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (sel_q == OP_MUL) begin
          // One multiplier bit per cycle; the final partial sum goes straight to the FIFO.
          if (it_q == IT_LAST) begin
            push    = 1'b1;
            push_c  = acc_sum;
            state_d = ST_IDLE;
          end else begin
            acc_d = acc_sum;
            a_d   = a_q << 1;
            b_d   = b_q >> 1;
            it_d  = it_q + 1'b1;
          end
        end else begin
          push     = 1'b1;
          push_c   = alu_c;
          push_err = alu_err;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= '0;
      acc_q   <= '0;
      it_q    <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sel_q   <= sel_d;
      acc_q   <= acc_d;
      it_q    <= it_d;
    end
  end

  // Only one command is in flight and accept requires a free slot, so push never sees a full FIFO.
  alu_rsp_fifo #(
    .W     (RES_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_data  ({push_err, push_c}),
    .pop        (pop),
    .head_valid (rsp_valid),
    .head_data  (head_data),
    .count      (fifo_count)
  );

  assign rsp_c   = head_data[RES_W-1:0];
  assign rsp_err = head_data[RES_W];

`ifdef ALU_CMD_STATS_EN
  logic [15:0] stat_ops_q, stat_ops_d;
  logic [15:0] stat_err_q, stat_err_d;

  always_comb begin
    stat_ops_d = stat_ops_q;
    stat_err_d = stat_err_q;
    if (push && (stat_ops_q != 16'hFFFF)) stat_ops_d = stat_ops_q + 16'd1;
    if (push && push_err && (stat_err_q != 16'hFFFF)) stat_err_d = stat_err_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_ops_q <= '0;
      stat_err_q <= '0;
    end else begin
      stat_ops_q <= stat_ops_d;
      stat_err_q <= stat_err_d;
    end
  end

  assign stat_ops = stat_ops_q;
  assign stat_err = stat_err_q;
`endif

endmodule

// File: tb/tb_alu_cmd_responder.sv
// tb/tb_alu_cmd_responder.sv - directed self-checking bench for alu_cmd_responder
module tb_alu_cmd_responder;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;
  logic [3:0] cmd_sel;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_c;
  logic       rsp_err;
`ifdef ALU_CMD_STATS_EN
  logic [15:0] stat_ops;
  logic [15:0] stat_err;
  int          ops_done;
`endif

  int total;
  int bad;

  alu_cmd_responder #(
    .DATA_W     (4),
    .FIFO_DEPTH (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_sel   (cmd_sel),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_c     (rsp_c),
`ifdef ALU_CMD_STATS_EN
    .stat_ops  (stat_ops),
    .stat_err  (stat_err),
`endif
    .rsp_err   (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic issue(input logic [3:0] a, input logic [3:0] b, input logic [3:0] sel);
    int n;
    n = 0;
    cmd_a = a;
    cmd_b = b;
    cmd_sel = sel;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("accept", {31'd0, cmd_ready}, 32'd1);
    if (cmd_ready) begin
      @(posedge clk);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
`ifdef ALU_CMD_STATS_EN
    ops_done++;
`endif
  endtask

  // Issue with rsp_ready=1 and check latency, result and the pop that follows.
  task automatic do_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] sel, input logic [7:0] exp_c,
                       input logic exp_err, input int lat);
    issue(a, b, sel);
    for (int i = 0; i < lat; i++) begin
      check({tag, "_early_valid"}, {31'd0, rsp_valid}, 32'd0);
      check({tag, "_busy_ready"}, {31'd0, cmd_ready}, 32'd0);
      @(negedge clk);
    end
    check({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
    check({tag, "_c"}, {24'd0, rsp_c}, {24'd0, exp_c});
    check({tag, "_err"}, {31'd0, rsp_err}, {31'd0, exp_err});
    @(negedge clk);
    check({tag, "_popped"}, {31'd0, rsp_valid}, 32'd0);
  endtask

  logic [7:0] xor_exp [5];

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_a = '0;
    cmd_b = '0;
    cmd_sel = '0;
    rsp_ready = 1'b0;
`ifdef ALU_CMD_STATS_EN
    ops_done = 0;
`endif
    xor_exp[0] = 8'h0E;
    xor_exp[1] = 8'h0D;
    xor_exp[2] = 8'h0C;
    xor_exp[3] = 8'h0B;
    xor_exp[4] = 8'h0A;

    repeat (3) @(negedge clk);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_c", {24'd0, rsp_c}, 32'd0);
    check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    rsp_ready = 1'b1;
    do_op("add",  4'd2,  4'd8,  4'b0000, 8'h0A, 1'b0, 1);
    do_op("sub",  4'd2,  4'd8,  4'b1111, 8'hFA, 1'b0, 1);
    do_op("shl",  4'd8,  4'd7,  4'b0110, 8'h00, 1'b0, 1);
    do_op("shl2", 4'd9,  4'd4,  4'b0110, 8'h90, 1'b0, 1);
    do_op("shr",  4'd2,  4'd1,  4'b1100, 8'h01, 1'b0, 1);
    do_op("eq",   4'd9,  4'd9,  4'b1000, 8'h01, 1'b0, 1);
    do_op("gt",   4'd7,  4'd15, 4'b0011, 8'h00, 1'b0, 1);
    do_op("gt2",  4'd15, 4'd7,  4'b0011, 8'h01, 1'b0, 1);
    do_op("and",  4'd12, 4'd10, 4'b0001, 8'h08, 1'b0, 1);
    do_op("or",   4'd12, 4'd10, 4'b0010, 8'h0E, 1'b0, 1);
    do_op("mul",  4'd11, 4'd7,  4'b0101, 8'h4D, 1'b0, 4);
    do_op("mul2", 4'd15, 4'd15, 4'b0101, 8'hE1, 1'b0, 4);
    do_op("ill",  4'd3,  4'd4,  4'b0111, 8'h00, 1'b1, 1);
`ifdef ALU_CMD_STATS_EN
    check("stat_err", {16'd0, stat_err}, 32'd1);
    check("stat_ops", {16'd0, stat_ops}, ops_done);
`endif

    // Fill the FIFO with rsp_ready low; the 5th command must stall until one pop.
    rsp_ready = 1'b0;
    for (int i = 1; i <= 4; i++) issue(4'd15, 4'(i), 4'b0100);
    cmd_a = 4'd15;
    cmd_b = 4'd5;
    cmd_sel = 4'b0100;
    cmd_valid = 1'b1;
    @(negedge clk);
    check("full_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check("full_head", {24'd0, rsp_c}, {24'd0, xor_exp[0]});
    @(negedge clk);
    check("full_hold_ready", {31'd0, cmd_ready}, 32'd0);
    check("full_hold_head", {24'd0, rsp_c}, {24'd0, xor_exp[0]});
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("after_pop_ready", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("fifth_busy", {31'd0, cmd_ready}, 32'd0);
    @(negedge clk);
    rsp_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      check("order_valid", {31'd0, rsp_valid}, 32'd1);
      check("order_c", {24'd0, rsp_c}, {24'd0, xor_exp[i]});
      @(negedge clk);
    end
    check("drained_valid", {31'd0, rsp_valid}, 32'd0);
    check("drained_c", {24'd0, rsp_c}, 32'd0);

    // Reset during the 2nd MUL cycle with two entries queued.
    rsp_ready = 1'b0;
    issue(4'd1, 4'd1, 4'b0000);
    issue(4'd1, 4'd2, 4'b0000);
    issue(4'd3, 4'd3, 4'b0101);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_rst_ready", {31'd0, cmd_ready}, 32'd0);
    check("abort_valid_in_rst", {31'd0, rsp_valid}, 32'd0);
    rst = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("abort_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("abort_rsp_c", {24'd0, rsp_c}, 32'd0);
    check("abort_rsp_err", {31'd0, rsp_err}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      check("abort_no_stale", {31'd0, rsp_valid}, 32'd0);
      @(negedge clk);
    end
`ifdef ALU_CMD_STATS_EN
    check("abort_stat_ops", {16'd0, stat_ops}, 32'd0);
`endif
    do_op("post_abort_add", 4'd3, 4'd4, 4'b0000, 8'h07, 1'b0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
